// File: rtl/fpa_pkg.sv
// Shared types and constants for the binary32 adder sequencer.
package fpa_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned FRAC_W   = 23;
    localparam int unsigned MANT_W   = FRAC_W + 1;
    localparam int unsigned SUM_W    = MANT_W + 1;
    localparam int unsigned EXPI_W   = 10;
    localparam int unsigned SHAMT_W  = 5;
    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 255;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } unpacked_t;

    // Split a binary32 word; denormals flush to a zero mantissa.
    function automatic unpacked_t unpack_fp(input logic [WORD_W-1:0] v);
        unpacked_t u;
        u.sign = v[WORD_W-1];
        u.exp  = v[WORD_W-2 -: EXP_W];
        u.mant = (u.exp != '0) ? {1'b1, v[FRAC_W-1:0]} : '0;
        return u;
    endfunction

endpackage

// File: rtl/lead_one_norm.sv
// Leading-one detect over the 25-bit sum and matching left shift into a 24-bit mantissa.
module lead_one_norm
    import fpa_pkg::*;
(
    input  logic [SUM_W-1:0]   sum,
    output logic [MANT_W-1:0]  norm_c,
    output logic [SHAMT_W-1:0] shamt_c
);

    logic [SHAMT_W-1:0] pos;

    // shamt is measured in the 25-bit frame: 0 means carry-out (net right shift by one).
    always_comb begin
        pos = '0;
        for (int i = 0; i < SUM_W; i++) begin
            if (sum[i]) pos = SHAMT_W'(i);
        end
        shamt_c = SHAMT_W'(SUM_W - 1) - pos;
        norm_c  = MANT_W'((sum << shamt_c) >> 1);
    end

endmodule

// File: rtl/fpa_seq_ctrl.sv
// Multi-cycle binary32 adder sequencer: capture, align, add/sub, normalize, hand off.
module fpa_seq_ctrl
    import fpa_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] result,
    output logic              overflow,
    output logic              busy
);

    state_t state_q, state_d;
    logic   in_ready_d, out_valid_d, busy_d;

    logic [WORD_W-1:0]  a_q, b_q;
    unpacked_t          x_q;
    logic [MANT_W-1:0]  ym_q;
    logic               sub_q;
    logic               special_q;
    logic [WORD_W-1:0]  spec_res_q;
    logic [SUM_W-1:0]   sum_q;
    logic               sign_q;
    logic signed [EXPI_W-1:0] exp_q;

    unpacked_t          ua_c, ub_c, x_c, y_c;
    logic [EXP_W-1:0]   ediff_c;
    logic [MANT_W-1:0]  ym_c;
    logic               special_c;
    logic [WORD_W-1:0]  spec_res_c;
    logic [SUM_W-1:0]   sum_c;
    logic [MANT_W-1:0]  norm_c;
    logic [SHAMT_W-1:0] shamt_c;
    logic signed [EXPI_W-1:0] exp_adj_c;
    logic               le_zero_c, ge_max_c;
    logic [WORD_W-1:0]  res_c;
    logic               ov_c;

    // State and handshake flags registered together so outputs track the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid && in_ready) state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b1;
        if (state_d == IDLE) begin
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
        end
        if (state_d == DONE) out_valid_d = 1'b1;
    end

    // Alignment: larger magnitude becomes X, Y mantissa shifted right by the exponent gap.
    always_comb begin
        ua_c       = unpack_fp(a_q);
        ub_c       = unpack_fp(b_q);
        x_c        = ua_c;
        y_c        = ub_c;
        if (a_q[WORD_W-2:0] < b_q[WORD_W-2:0]) begin
            x_c = ub_c;
            y_c = ua_c;
        end
        ediff_c    = x_c.exp - y_c.exp;
        ym_c       = (ediff_c >= EXP_W'(MANT_W)) ? '0 : (y_c.mant >> ediff_c);
        special_c  = (ua_c.exp == EXP_W'(EXP_MAX)) || (ub_c.exp == EXP_W'(EXP_MAX));
        spec_res_c = (ua_c.exp == EXP_W'(EXP_MAX)) ? a_q : b_q;
    end

    always_comb begin
        sum_c = '0;
        if (sub_q) sum_c = {1'b0, x_q.mant} - {1'b0, ym_q};
        else       sum_c = {1'b0, x_q.mant} + {1'b0, ym_q};
    end

    lead_one_norm u_lead_one_norm (
        .sum     (sum_q),
        .norm_c  (norm_c),
        .shamt_c (shamt_c)
    );

    // Normalize and pack; exponent range checks use the signed 10-bit intermediate.
    always_comb begin
        exp_adj_c = exp_q + EXPI_W'(1) - EXPI_W'(shamt_c);
        le_zero_c = exp_adj_c[EXPI_W-1] || (exp_adj_c == '0);
        ge_max_c  = !exp_adj_c[EXPI_W-1] && (exp_adj_c >= EXPI_W'(EXP_MAX));
        res_c     = {sign_q, EXP_W'(exp_adj_c), FRAC_W'(norm_c)};
        ov_c      = 1'b0;
        if (special_q) begin
            res_c = spec_res_q;
        end else if (sum_q == '0) begin
            res_c = '0;
        end else if (le_zero_c) begin
            res_c = {sign_q, {(EXP_W + FRAC_W){1'b0}}};
        end else if (ge_max_c) begin
            res_c = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ov_c  = 1'b1;
        end
    end

    // Datapath registers advance only in the stage that owns them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            x_q        <= '0;
            ym_q       <= '0;
            sub_q      <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            sum_q      <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            result     <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q <= a;
                        b_q <= b;
                    end
                end
                ALIGN: begin
                    x_q        <= x_c;
                    ym_q       <= ym_c;
                    sub_q      <= x_c.sign ^ y_c.sign;
                    special_q  <= special_c;
                    spec_res_q <= spec_res_c;
                end
                ADD: begin
                    sum_q  <= sum_c;
                    sign_q <= x_q.sign;
                    exp_q  <= EXPI_W'(x_q.exp);
                end
                NORM: begin
                    result   <= res_c;
                    overflow <= ov_c;
                end
                default: ;
            endcase
        end
    end

endmodule
